// File: rtl/bus_region_decoder_pkg.sv
// bus_region_decoder_pkg: shared state encoding, region indices and field widths
package bus_region_decoder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLASH, S_ACK} state_t;
  localparam int WS_WIDTH = 4;
  localparam int CNT_WIDTH = 16;
  localparam int REGION_CPU_RAM = 0;
  localparam int REGION_VDP = 1;
  localparam int REGION_STATUS = 2;
  localparam int REGION_DSP = 3;
  localparam int REGION_PAD = 4;
  localparam int REGION_COP_RAM = 5;
endpackage

// File: rtl/bus_region_decoder_wait_counter.sv
// bus_region_decoder_wait_counter: loadable up/down counter with terminal-value flag
module bus_region_decoder_wait_counter
  import bus_region_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 up,
  input  logic [CNT_WIDTH-1:0] value,
  input  logic [CNT_WIDTH-1:0] term,
  output logic                 done
);
  logic [CNT_WIDTH-1:0] count;
  // load takes priority over stepping
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (step) count <= up ? count + 1'b1 : count - 1'b1;
  assign done = count == term;
endmodule

// File: rtl/bus_region_decoder.sv
// bus_region_decoder: native-bus region decoder with wait states, flash timeout and bus errors
module bus_region_decoder
  import bus_region_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int REGION_BITS = 3,
  parameter logic [2**REGION_BITS-1:0] REGION_MASK = 8'b0011_1111,
  parameter logic [WS_WIDTH*(2**REGION_BITS)-1:0] WAIT_STATES = 32'h0000_0000,
  parameter int FLASH_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    cpu_address,
  input  logic                     cpu_mem_valid,
  input  logic [3:0]               cpu_wstrb,
  output logic                     cpu_mem_ready,
  output logic                     bus_error,
  output logic [ADDR_WIDTH-1:0]    error_address,
  output logic [2**REGION_BITS-1:0] region_en,
  output logic [2**REGION_BITS-1:0] region_write_en,
  output logic                     flash_read_en,
  input  logic                     flash_ready
);
  localparam int REGIONS = 2**REGION_BITS;
  state_t state, next;
  logic [REGION_BITS-1:0] region;
  logic [WS_WIDTH-1:0] ws;
  logic flash, mapped, active, err, done;
  assign region = cpu_address[ADDR_WIDTH-2 -: REGION_BITS];
  assign flash = cpu_address[ADDR_WIDTH-1];
  assign mapped = REGION_MASK[region];
  assign ws = WAIT_STATES[region*WS_WIDTH +: WS_WIDTH];
  assign active = cpu_mem_valid && !reset && state != S_ACK;
  assign region_en = (active && !flash && mapped) ? REGIONS'(1) << region : '0;
  assign region_write_en = |cpu_wstrb ? region_en : '0;
  assign flash_read_en = active && flash;
  bus_region_decoder_wait_counter u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (state == S_IDLE),
    .step  (state == S_WAIT || state == S_FLASH),
    .up    (state == S_FLASH),
    .value (flash ? '0 : CNT_WIDTH'(ws) - 1'b1),
    .term  (state == S_FLASH ? CNT_WIDTH'(FLASH_TIMEOUT - 2) : '0),
    .done  (done)
  );
  // next-state and error-pending decision; dropped valid abandons the access
  always_comb begin
    next = state;
    err = 1'b0;
    case (state)
      S_IDLE: begin
        next = !cpu_mem_valid ? S_IDLE :
               flash ? ((flash_ready || FLASH_TIMEOUT == 1) ? S_ACK : S_FLASH) :
               (!mapped || ws == '0) ? S_ACK : S_WAIT;
        err = cpu_mem_valid && (flash ? !flash_ready && FLASH_TIMEOUT == 1 : !mapped);
      end
      S_WAIT: next = !cpu_mem_valid ? S_IDLE : done ? S_ACK : S_WAIT;
      S_FLASH: begin
        next = !cpu_mem_valid ? S_IDLE : (flash_ready || done) ? S_ACK : S_FLASH;
        err = cpu_mem_valid && !flash_ready && done;
      end
      default: next = S_IDLE;
    endcase
  end
  // state plus registered acknowledge, error pulse and error address capture
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      cpu_mem_ready <= 1'b0;
      bus_error <= 1'b0;
      error_address <= '0;
    end else begin
      state <= next;
      cpu_mem_ready <= next == S_ACK;
      bus_error <= next == S_ACK && err;
      if (next == S_ACK && err) error_address <= cpu_address;
    end
endmodule

// File: tb/tb_bus_region_decoder.sv
// tb_bus_region_decoder: table, hand-written and random checks against a latency model
module tb_bus_region_decoder;
  localparam int AW = 20;
  localparam int T = 8;
  localparam logic [7:0] MASK = 8'b0011_1111;
  localparam logic [31:0] WS = 32'h0002_1530;
  logic clk = 0, reset = 1, cpu_mem_valid = 0, flash_ready = 0;
  logic [AW-1:0] cpu_address = '0;
  logic [3:0] cpu_wstrb = '0;
  logic cpu_mem_ready, bus_error, flash_read_en;
  logic [AW-1:0] error_address;
  logic [7:0] region_en, region_write_en;
  int checks = 0, failures = 0;
  typedef struct {
    logic [19:0] addr;
    logic [3:0]  wstrb;
    int          fr;
    int          lat;
    logic        err;
    logic [7:0]  en;
    logic        fre;
  } vec_t;
  vec_t tbl[13];
  bus_region_decoder #(
    .ADDR_WIDTH(AW), .REGION_BITS(3), .REGION_MASK(MASK),
    .WAIT_STATES(WS), .FLASH_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_mem_valid(cpu_mem_valid),
    .cpu_wstrb(cpu_wstrb), .cpu_mem_ready(cpu_mem_ready), .bus_error(bus_error),
    .error_address(error_address), .region_en(region_en), .region_write_en(region_write_en),
    .flash_read_en(flash_read_en), .flash_ready(flash_ready)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [18:0] obs();
    return {cpu_mem_ready, bus_error, region_en, region_write_en, flash_read_en};
  endfunction
  function automatic logic [18:0] want(logic rdy, logic er, logic [7:0] en, logic [7:0] wen, logic fre);
    return {rdy, er, en, wen, fre};
  endfunction
  // reference: latency, error and enables derived directly from the access rules
  function automatic vec_t model(logic [19:0] a, logic [3:0] wstrb, int fr);
    vec_t v;
    logic [7:0] m = MASK;
    logic [31:0] w = WS;
    int r = int'(a[18:16]);
    int nws = int'((w >> (4 * r)) & 32'hF);
    v.addr = a; v.wstrb = wstrb; v.fr = fr; v.fre = a[19];
    if (a[19]) begin
      v.err = !(fr >= 0 && fr < T);
      v.lat = v.err ? T : fr + 1;
      v.en = 8'h0;
    end else begin
      v.err = !m[r];
      v.lat = v.err ? 1 : nws + 1;
      v.en = v.err ? 8'h0 : 8'(1 << r);
    end
    return v;
  endfunction
  task automatic access(string name, vec_t v);
    logic [7:0] wen;
    wen = |v.wstrb ? v.en : 8'h0;
    cpu_mem_valid = 1; cpu_address = v.addr; cpu_wstrb = v.wstrb; flash_ready = (v.fr == 0);
    for (int c = 0; c <= v.lat; c++) begin
      @(negedge clk);
      if (c < v.lat) check(name, 32'(obs()), 32'(want(0, 0, v.en, wen, v.fre)));
      else begin
        check({name, " ack"}, 32'(obs()), 32'(want(1, v.err, 8'h0, 8'h0, 0)));
        if (v.err) check({name, " err_addr"}, 32'(error_address), 32'(v.addr));
      end
      @(posedge clk); #1;
      flash_ready = (c + 1 == v.fr);
    end
    cpu_mem_valid = 0; flash_ready = 0;
    @(negedge clk);
    check({name, " idle"}, 32'(obs()), 32'h0);
    @(posedge clk); #1;
  endtask
  initial begin
    tbl[0]  = '{20'h00010, 4'h0, -1, 1, 1'b0, 8'h01, 1'b0};
    tbl[1]  = '{20'h10004, 4'hF, -1, 4, 1'b0, 8'h02, 1'b0};
    tbl[2]  = '{20'h60000, 4'h0, -1, 1, 1'b1, 8'h00, 1'b0};
    tbl[3]  = '{20'h80000, 4'h0,  5, 6, 1'b0, 8'h00, 1'b1};
    tbl[4]  = '{20'h80000, 4'h0, -1, 8, 1'b1, 8'h00, 1'b1};
    tbl[5]  = '{20'h30000, 4'h3, -1, 2, 1'b0, 8'h08, 1'b0};
    tbl[6]  = '{20'h70000, 4'h0, -1, 1, 1'b1, 8'h00, 1'b0};
    tbl[7]  = '{20'h80000, 4'h0,  0, 1, 1'b0, 8'h00, 1'b1};
    tbl[8]  = '{20'hFFFFF, 4'h0,  7, 8, 1'b0, 8'h00, 1'b1};
    tbl[9]  = '{20'h4FFFC, 4'h1, -1, 3, 1'b0, 8'h10, 1'b0};
    tbl[10] = '{20'h50000, 4'h8, -1, 1, 1'b0, 8'h20, 1'b0};
    tbl[11] = '{20'h80000, 4'h0,  8, 8, 1'b1, 8'h00, 1'b1};
    tbl[12] = '{20'h20000, 4'h0, -1, 6, 1'b0, 8'h04, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'(obs()), 32'h0);
    check("reset err_addr", 32'(error_address), 32'h0);
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 13; i++) access($sformatf("table%0d", i), tbl[i]);
    // reset in the middle of a 5-wait-state access
    cpu_mem_valid = 1; cpu_address = 20'h20000; cpu_wstrb = 4'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_mid en", 32'(obs()), 32'(want(0, 0, 8'h04, 8'h00, 0)));
      @(posedge clk); #1;
    end
    reset = 1;
    @(negedge clk);
    check("rst_mid gated", 32'(obs()), 32'h0);
    @(posedge clk); #1;
    reset = 0; cpu_mem_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_mid after", 32'(obs()), 32'h0);
      check("rst_mid err_addr", 32'(error_address), 32'h0);
      @(posedge clk); #1;
    end
    access("post_reset", tbl[0]);
    // valid dropped during wait states: no acknowledge
    cpu_mem_valid = 1; cpu_address = 20'h10000; cpu_wstrb = 4'h0;
    @(negedge clk);
    check("drop en", 32'(obs()), 32'(want(0, 0, 8'h02, 8'h00, 0)));
    @(posedge clk); #1;
    cpu_mem_valid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("drop no_ready", 32'(obs()), 32'h0);
      @(posedge clk); #1;
    end
    access("post_drop", tbl[1]);
    // back-to-back region-0 reads with valid held
    cpu_mem_valid = 1; cpu_address = 20'h00010; cpu_wstrb = 4'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("b2b c%0d", c), 32'(obs()),
            32'((c % 2) ? want(1, 0, 8'h00, 8'h00, 0) : want(0, 0, 8'h01, 8'h00, 0)));
      @(posedge clk); #1;
    end
    cpu_mem_valid = 0;
    @(negedge clk);
    check("b2b idle", 32'(obs()), 32'h0);
    @(posedge clk); #1;
    // randomized accesses against the model
    for (int i = 0; i < 60; i++) begin
      logic [19:0] a;
      logic [3:0] s;
      int fr;
      a = 20'($urandom);
      s = 4'($urandom);
      fr = int'($urandom_range(0, 10)) - 1;
      access($sformatf("rand%0d a=%h fr=%0d", i, a, fr), model(a, s, fr));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
